// File: rtl/aline_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : aline_pingpong_buffer
// Brief    : Two-bank A-line capture buffer in the ADC clock domain. Captures
//            NSAMPLES samples per sweep trigger into one bank while the reader
//            drains the other, with a ready/ack handshake per committed line
//            and pulses for dropped (overrun) and cut-short (abort) sweeps.
// Options  : ALINE_TAG_EN - when defined, sample 0 of every line holds the
//            pre-increment line_count instead of ADC data.
// Revision : 1.0 - initial release
// ============================================================================
module aline_pingpong_buffer #(
   parameter int NSAMPLES = 1170,
   parameter int AW       = 11,
   parameter int DW       = 14
) (
   input  logic          ADC_data_out_clk,
   input  logic          global_reset_n,
   input  logic          trigger,
   input  logic [DW-1:0] adc_data,
   output logic          line_ready,
   output logic          line_bank,
   input  logic          line_ack,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [15:0]   line_count,
   output logic          acq_busy,
   output logic          overrun,
   output logic          abort
);

   localparam int            c_DEPTH    = 2 ** (AW + 1);
   localparam logic [AW-1:0] c_LAST_PTR = AW'(NSAMPLES - 1);
   localparam logic [AW:0]   c_NSAMP    = (AW + 1)'(NSAMPLES);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_CAPTURE = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          trig_meta_q, trig_sync_q, trig_dly_q;
   logic [DW-1:0] adc_q;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [1:0]    full_q, full_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [15:0]   line_count_q, line_count_d;
   logic          overrun_q, overrun_d;
   logic          abort_q, abort_d;
   logic [DW-1:0] rd_data_q;
   logic [DW-1:0] ram_q [c_DEPTH];

   logic          w_trig_edge;
   logic          w_wr_en;
   logic [DW-1:0] w_wr_data;

   assign w_trig_edge = trig_sync_q & ~trig_dly_q;

`ifdef ALINE_TAG_EN
   // Word 0 carries the line number so the reader can detect dropped lines.
   assign w_wr_data = (wr_ptr_q == '0) ? DW'(line_count_q) : adc_q;
`else
   assign w_wr_data = adc_q;
`endif

   // Trigger synchronizer plus one delay stage for rising-edge detection.
   always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         trig_meta_q <= 1'b0;
         trig_sync_q <= 1'b0;
         trig_dly_q  <= 1'b0;
      end else begin
         trig_meta_q <= trigger;
         trig_sync_q <= trig_meta_q;
         trig_dly_q  <= trig_sync_q;
      end
   end

   // Single register stage on the ADC sample aligns sample 0 with the edge cycle.
   always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         adc_q <= '0;
      end else begin
         adc_q <= adc_data;
      end
   end

   // Capture FSM, bank bookkeeping and status pulse registers.
   always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state_q      <= S_IDLE;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         full_q       <= 2'b00;
         wr_ptr_q     <= '0;
         line_count_q <= '0;
         overrun_q    <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         full_q       <= full_d;
         wr_ptr_q     <= wr_ptr_d;
         line_count_q <= line_count_d;
         overrun_q    <= overrun_d;
         abort_q      <= abort_d;
      end
   end

   // Next-state logic: capture side commits banks, reader side releases them.
   always_comb begin
      state_d      = state_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      full_d       = full_q;
      wr_ptr_d     = wr_ptr_q;
      line_count_d = line_count_q;
      overrun_d    = 1'b0;
      abort_d      = 1'b0;
      w_wr_en      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_trig_edge) begin
               if (full_q[wr_bank_q]) begin
                  overrun_d = 1'b1;
               end else begin
                  state_d  = S_CAPTURE;
                  wr_ptr_d = '0;
               end
            end
         end
         S_CAPTURE: begin
            // A falling trigger wins over the write: the partial bank is dropped.
            if (!trig_sync_q) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               w_wr_en  = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == c_LAST_PTR) begin
                  full_d[wr_bank_q] = 1'b1;
                  wr_bank_d         = ~wr_bank_q;
                  line_count_d      = line_count_q + 16'd1;
                  state_d           = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A commit in the same cycle always targets the other bank, so both apply.
      if (line_ack && full_q[rd_bank_q]) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   // Sample RAM write port; contents deliberately survive reset.
   always_ff @(posedge ADC_data_out_clk) begin
      if (w_wr_en) begin
         ram_q[{wr_bank_q, wr_ptr_q}] <= w_wr_data;
      end
   end

   // Registered read port; addresses past the line length read back as zero.
   always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         rd_data_q <= '0;
      end else if ({1'b0, rd_addr} >= c_NSAMP) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= ram_q[{rd_bank_q, rd_addr}];
      end
   end

   assign line_ready = full_q[rd_bank_q];
   assign line_bank  = rd_bank_q;
   assign rd_data    = rd_data_q;
   assign line_count = line_count_q;
   assign acq_busy   = (state_q == S_CAPTURE);
   assign overrun    = overrun_q;
   assign abort      = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_aline_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aline_pingpong_buffer
// Brief    : Self-checking bench for aline_pingpong_buffer. Random ADC data and
//            sweep lengths; expected lines and commit times are queued at
//            stimulus time and consumed by independent reader/monitor threads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aline_pingpong_buffer;

   localparam int N    = 8;
   localparam int AW   = 4;
   localparam int DW   = 14;
   localparam int HIST = 16384;
`ifdef ALINE_TAG_EN
   localparam bit TAG = 1'b1;
`else
   localparam bit TAG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          trigger;
   logic [DW-1:0] adc_data;
   logic          line_ready, line_bank, line_ack;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [15:0]   line_count;
   logic          acq_busy, overrun, abort;

   always #5 clk = ~clk;

   aline_pingpong_buffer #(.NSAMPLES(N), .AW(AW), .DW(DW)) dut (
      .ADC_data_out_clk(clk),
      .global_reset_n  (rst_n),
      .trigger         (trigger),
      .adc_data        (adc_data),
      .line_ready      (line_ready),
      .line_bank       (line_bank),
      .line_ack        (line_ack),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .line_count      (line_count),
      .acq_busy        (acq_busy),
      .overrun         (overrun),
      .abort           (abort)
   );

   typedef struct {
      int n0;    // first clock edge that sampled trigger high
      int bank;
      int tag;
   } line_t;

   int      checks = 0, errors = 0;
   int      cyc = 0;
   logic [DW-1:0] adc_hist [HIST];
   line_t   exp_lines[$];
   int      commit_q[$];
   int      m_commits = 0, exp_ovr = 0, exp_abt = 0;
   int      ovr_cnt = 0, abt_cnt = 0, busy_total = 0;
   bit      rd_en = 1'b0, rd_busy = 1'b0;
   int      hold_ack_until = 0, last_ack_cyc = -1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Record the ADC value seen at every rising edge, indexed by edge number.
   always @(posedge clk) begin
      if (cyc < HIST) adc_hist[cyc] = adc_data;
      cyc = cyc + 1;
   end

   initial begin : adc_drv
      adc_data = '0;
      forever begin
         @(negedge clk);
         adc_data = DW'($urandom);
      end
   end

   // Reader: drains committed lines, compares every word, then acks.
   initial begin : reader
      line_t e;
      int    ev;
      line_ack = 1'b0;
      rd_addr  = '0;
      forever begin
         @(negedge clk);
         if (rd_en && rst_n && line_ready) begin
            rd_busy = 1'b1;
            if (exp_lines.size() == 0) begin
               check("line_expected", exp_lines.size(), 1);
            end else begin
               e = exp_lines[0];
               check("line_bank", line_bank, e.bank);
               for (int a = 0; a < 2 ** AW; a++) begin
                  rd_addr = AW'(a);
                  @(negedge clk);
                  if (a >= N)              ev = 0;
                  else if (a == 0 && TAG)  ev = e.tag;
                  else                     ev = adc_hist[e.n0 + 2 + a];
                  check($sformatf("rd_data[%0d]", a), rd_data, ev);
               end
               while (cyc < hold_ack_until) @(negedge clk);
            end
            last_ack_cyc = cyc;
            line_ack = 1'b1;
            @(negedge clk);
            line_ack = 1'b0;
            if (exp_lines.size() != 0) void'(exp_lines.pop_front());
            rd_busy = 1'b0;
         end
      end
   end

   // Monitor: counts pulses and checks every line_count change against commit queue.
   initial begin : monitor
      int prev_lc, busy_run, t;
      prev_lc  = 0;
      busy_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_lc  = 0;
            busy_run = 0;
         end else begin
            if (overrun)  ovr_cnt++;
            if (abort)    abt_cnt++;
            if (acq_busy) busy_total++;
            if (int'(line_count) != prev_lc) begin
               if (commit_q.size() == 0) begin
                  check("commit_expected", commit_q.size(), 1);
               end else begin
                  t = commit_q.pop_front();
                  check("commit_cycle", cyc, t);
                  check("line_count_step", line_count, (prev_lc + 1) % 65536);
                  check("line_ready_at_commit", line_ready, 1);
                  check("acq_busy_width", busy_run, N);
               end
            end
            busy_run = acq_busy ? busy_run + 1 : 0;
            prev_lc  = int'(line_count);
         end
      end
   end

   // One sweep; the model decides overrun / commit / abort from queue depth and length.
   task automatic sweep(input int hi);
      line_t e;
      if (exp_lines.size() >= 2) begin
         exp_ovr++;
      end else if (hi > N) begin
         e.n0   = cyc;
         e.bank = m_commits % 2;
         e.tag  = m_commits % (1 << DW);
         exp_lines.push_back(e);
         commit_q.push_back(cyc + 3 + N);
         m_commits++;
      end else begin
         exp_abt++;
      end
      trigger = 1'b1;
      repeat (hi) @(negedge clk);
      trigger = 1'b0;
      repeat ($urandom_range(4, 7)) @(negedge clk);
   endtask

   task automatic wait_slot();
      int b = 0;
      while (exp_lines.size() >= 2 && b < 1000) begin
         @(negedge clk);
         b++;
      end
      check("slot_wait", int'(exp_lines.size() < 2), 1);
   endtask

   task automatic drain();
      int b = 0;
      while ((exp_lines.size() != 0 || rd_busy) && b < 2000) begin
         @(negedge clk);
         b++;
      end
      check("drain", exp_lines.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_line_ready"}, line_ready, 0);
      check({tag, "_line_bank"},  line_bank, 0);
      check({tag, "_rd_data"},    rd_data, 0);
      check({tag, "_line_count"}, line_count, 0);
      check({tag, "_acq_busy"},   acq_busy, 0);
      check({tag, "_overrun"},    overrun, 0);
      check({tag, "_abort"},      abort, 0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int lc0, busy0, n0, n0b, hold, bankb;
      rst_n   = 1'b0;
      trigger = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Abort straight after reset, then the next full line must land in bank 0.
      rd_en = 1'b1;
      sweep(4);
      check("abort_count", abt_cnt, exp_abt);
      check("abort_line_ready", line_ready, 0);
      check("abort_line_count", line_count, 0);
      sweep(N + 4);
      drain();
      check("first_line_count", line_count, 1);

      // Random stream of full and aborted sweeps with a live reader.
      for (int i = 0; i < 12; i++) begin
         wait_slot();
         if ($urandom_range(0, 3) == 0) sweep($urandom_range(1, N));
         else                           sweep(N + 1 + $urandom_range(0, 4));
      end
      drain();
      check("stream_aborts", abt_cnt, exp_abt);
      check("stream_overruns", ovr_cnt, exp_ovr);
      check("stream_line_count", line_count, m_commits % 65536);

      // Both banks full with no reader: third sweep must be dropped.
      rd_en = 1'b0;
      sweep(N + 4);
      sweep(N + 4);
      check("two_full_line_count", line_count, m_commits % 65536);
      lc0   = int'(line_count);
      busy0 = busy_total;
      sweep(N + 4);
      check("overrun_count", ovr_cnt, exp_ovr);
      check("overrun_line_count", line_count, lc0);
      check("overrun_no_busy", busy_total - busy0, 0);
      check("overrun_line_ready", line_ready, 1);
      rd_en = 1'b1;
      drain();

      // Ack of the presented bank coinciding with commit of the other bank.
      rd_en = 1'b0;
      sweep(N + 4);
      n0b  = cyc + 30;
      hold = n0b + 2 + N;
      hold_ack_until = hold;
      rd_en = 1'b1;
      while (cyc < n0b) @(negedge clk);
      bankb = m_commits % 2;
      sweep(N + 4);
      check("simul_ack_cycle", last_ack_cyc, hold);
      check("simul_line_ready", line_ready, 1);
      check("simul_line_bank", line_bank, bankb);
      hold_ack_until = 0;
      drain();

      // Reset in the middle of a capture with a committed line still pending.
      rd_en = 1'b0;
      sweep(N + 4);
      trigger = 1'b1;
      n0 = cyc;
      while (cyc < n0 + 8) @(negedge clk);
      check("busy_before_reset", acq_busy, 1);
      check("ready_before_reset", line_ready, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async");
      exp_lines.delete();
      commit_q.delete();
      m_commits = 0;
      trigger = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rd_en = 1'b1;
      sweep(N + 4);
      drain();
      check("post_reset_line_count", line_count, 1);
      check("post_reset_bank", line_bank, 1);

      check("final_commit_queue", commit_q.size(), 0);
      check("final_overruns", ovr_cnt, exp_ovr);
      check("final_aborts", abt_cnt, exp_abt);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
